// File: rtl/dmem_dump_reader_pkg.sv
// Shared types and helpers for the post-run dmem dump reader:
// FSM state encoding, signature rotate amount and the signature update step.
package dmem_dump_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SIG_ROT = 1;

  // Rotate-left by SIG_ROT, then fold in the accepted word.
  function automatic logic [31:0] sig_update(input logic [31:0] sig,
                                             input logic [31:0] word);
    return ((sig << SIG_ROT) | (sig >> (32 - SIG_ROT))) ^ word;
  endfunction

endpackage

// File: rtl/dmem_dump_reader_rise_detect.sv
// Registered rising-edge detector: the registered copy of din is cleared by
// synchronous reset, so a level already high at reset release reports a rise.
module dmem_dump_reader_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (reset) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/dmem_dump_reader.sv
// Sweeps NWORDS words of dmem after finish rises, streams them over valid/ready
// with index and last flag, and accumulates a rotate-XOR signature.
module dmem_dump_reader
  import dmem_dump_reader_pkg::*;
#(
  parameter int          NWORDS    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          IW        = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          finish,
  output logic [31:0]   daddr,
  input  logic [31:0]   drdata,
  output logic [31:0]   dwdata,
  output logic [3:0]    dwe,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [IW-1:0] out_index,
  output logic          out_last,
  output logic          busy,
  output logic          dump_done,
  output logic [31:0]   signature
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_t        state, state_nxt;
  logic          start;
  logic          hs;
  logic [IW-1:0] idx;

  dmem_dump_reader_rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .din   (finish),
    .rise  (start)
  );

  assign hs     = out_valid & out_ready;
  assign dwdata = 32'h0;
  assign dwe    = 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Rises while READ/HOLD are busy are ignored; only IDLE and DONE act on start.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    dump_done = 1'b0;
    daddr     = BASE_ADDR;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        busy      = 1'b1;
        daddr     = BASE_ADDR + (32'(idx) << 2);
        state_nxt = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (hs) state_nxt = out_last ? DONE : READ;
      end
      DONE: begin
        dump_done = 1'b1;
        if (start) state_nxt = READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 32'h0;
      out_index <= '0;
      signature <= 32'h0;
    end else begin
      if ((state == IDLE || state == DONE) && start) begin
        idx       <= '0;
        signature <= 32'h0;
      end
      if (state == READ) begin
        out_data  <= drdata;
        out_index <= idx;
        out_last  <= (idx == LAST_IDX);
        out_valid <= 1'b1;
      end
      if (state == HOLD && hs) begin
        out_valid <= 1'b0;
        signature <= sig_update(signature, out_data);
        if (!out_last) idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench: a 4-word instance at base 0 and a 32-word instance at base 0x80.
module tb_dmem_dump_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-word instance
  logic        a_finish, a_ready, a_valid, a_last, a_busy, a_done;
  logic [31:0] a_daddr, a_drdata, a_dwdata, a_data, a_sig;
  logic [3:0]  a_dwe;
  logic [1:0]  a_index;
  logic [31:0] mem4 [4];

  // 32-word instance
  logic        b_finish, b_ready, b_valid, b_last, b_busy, b_done;
  logic [31:0] b_daddr, b_drdata, b_dwdata, b_data, b_sig;
  logic [3:0]  b_dwe;
  logic [4:0]  b_index;
  logic [31:0] mem32 [32];

  assign a_drdata = mem4[a_daddr[3:2]];
  assign b_drdata = mem32[b_daddr[6:2]];

  dmem_dump_reader #(.NWORDS(4), .BASE_ADDR(32'h0), .IW(2)) dut_a (
    .clk(clk), .reset(reset), .finish(a_finish), .daddr(a_daddr),
    .drdata(a_drdata), .dwdata(a_dwdata), .dwe(a_dwe), .out_valid(a_valid),
    .out_ready(a_ready), .out_data(a_data), .out_index(a_index),
    .out_last(a_last), .busy(a_busy), .dump_done(a_done), .signature(a_sig)
  );

  dmem_dump_reader #(.NWORDS(32), .BASE_ADDR(32'h80), .IW(5)) dut_b (
    .clk(clk), .reset(reset), .finish(b_finish), .daddr(b_daddr),
    .drdata(b_drdata), .dwdata(b_dwdata), .dwe(b_dwe), .out_valid(b_valid),
    .out_ready(b_ready), .out_data(b_data), .out_index(b_index),
    .out_last(b_last), .busy(b_busy), .dump_done(b_done), .signature(b_sig)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  index;
    logic        last;
  } vec_t;

  vec_t tbl [4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    chk("a_dwe", 32'(a_dwe), 32'h0);
    chk("b_dwe", 32'(b_dwe), 32'h0);
    chk("a_dwdata", a_dwdata, 32'h0);
    chk("b_dwdata", b_dwdata, 32'h0);
  endtask

  function automatic logic [31:0] sig_model32();
    logic [31:0] s = 32'h0;
    for (int i = 0; i < 32; i++) s = {s[30:0], s[31]} ^ mem32[i];
    return s;
  endfunction

  // Full 4-word dump: optional stall on one word, optional finish toggle mid-dump.
  task automatic dump_a(input int stall_idx, input int stall_cycles, input bit retrig);
    logic [31:0] sig_hold;
    a_finish = 1'b0;
    step();
    a_finish = 1'b1;
    step();
    chk("a_start_sig_clear", a_sig, 32'h0);
    chk("a_start_busy", 32'(a_busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_daddr[%0d]", i), a_daddr, tbl[i].addr);
      step();
      chk($sformatf("a_valid[%0d]", i), 32'(a_valid), 32'h1);
      chk($sformatf("a_data[%0d]", i), a_data, tbl[i].data);
      chk($sformatf("a_index[%0d]", i), 32'(a_index), 32'(tbl[i].index));
      chk($sformatf("a_last[%0d]", i), 32'(a_last), 32'(tbl[i].last));
      chk($sformatf("a_done_early[%0d]", i), 32'(a_done), 32'h0);
      if (i == stall_idx) begin
        sig_hold = a_sig;
        a_ready = 1'b0;
        for (int c = 0; c < stall_cycles; c++) begin
          step();
          chk("stall_valid", 32'(a_valid), 32'h1);
          chk("stall_data", a_data, tbl[i].data);
          chk("stall_index", 32'(a_index), 32'(tbl[i].index));
          chk("stall_sig", a_sig, sig_hold);
          chk("stall_daddr", a_daddr, 32'h0);
        end
        a_ready = 1'b1;
      end
      if (retrig && i == 1) a_finish = 1'b0;
      if (retrig && i == 2) a_finish = 1'b1;
      step();
    end
    chk("a_dump_done", 32'(a_done), 32'h1);
    chk("a_busy_done", 32'(a_busy), 32'h0);
    chk("a_valid_done", 32'(a_valid), 32'h0);
    chk("a_signature", a_sig, 32'h0000_0002);
  endtask

  initial begin
    tbl[0] = '{addr: 32'h0, data: 32'h1, index: 2'd0, last: 1'b0};
    tbl[1] = '{addr: 32'h4, data: 32'h2, index: 2'd1, last: 1'b0};
    tbl[2] = '{addr: 32'h8, data: 32'h3, index: 2'd2, last: 1'b0};
    tbl[3] = '{addr: 32'hC, data: 32'h4, index: 2'd3, last: 1'b1};
    for (int i = 0; i < 4; i++) mem4[i] = tbl[i].data;
    for (int i = 0; i < 32; i++) mem32[i] = $urandom;

    reset = 1'b1;
    a_finish = 1'b0; a_ready = 1'b1;
    b_finish = 1'b0; b_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(a_valid), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_done", 32'(a_done), 32'h0);
    chk("rst_sig", a_sig, 32'h0);
    chk("rst_daddr_b", b_daddr, 32'h80);
    reset = 1'b0;
    repeat (5) step();
    chk("idle_busy", 32'(a_busy), 32'h0);

    // Basic dump, then sticky DONE with finish held high
    dump_a(-1, 0, 1'b0);
    repeat (3) step();
    chk("done_sticky", 32'(a_done), 32'h1);
    chk("done_sticky_busy", 32'(a_busy), 32'h0);

    // Restart from DONE with backpressure on word 1
    dump_a(1, 5, 1'b0);

    // Finish toggled mid-dump: rise ignored, single completion
    dump_a(-1, 0, 1'b1);
    step();
    chk("retrig_once_done", 32'(a_done), 32'h1);
    chk("retrig_once_busy", 32'(a_busy), 32'h0);

    // Reset while holding word 2; finish stays high so start fires after release
    a_finish = 1'b0;
    step();
    a_finish = 1'b1;
    repeat (5) step();
    a_ready = 1'b0;
    step();
    chk("mid_hold_index", 32'(a_index), 32'h2);
    chk("mid_hold_valid", 32'(a_valid), 32'h1);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(a_valid), 32'h0);
    chk("mid_rst_last", 32'(a_last), 32'h0);
    chk("mid_rst_busy", 32'(a_busy), 32'h0);
    chk("mid_rst_done", 32'(a_done), 32'h0);
    chk("mid_rst_data", a_data, 32'h0);
    chk("mid_rst_index", 32'(a_index), 32'h0);
    chk("mid_rst_sig", a_sig, 32'h0);
    chk("mid_rst_daddr", a_daddr, 32'h0);
    reset = 1'b0;
    a_ready = 1'b1;
    step();
    chk("post_rst_busy", 32'(a_busy), 32'h1);
    chk("post_rst_daddr", a_daddr, 32'h0);
    step();
    chk("post_rst_index", 32'(a_index), 32'h0);
    chk("post_rst_data", a_data, 32'h1);
    repeat (6) step();
    chk("post_rst_done_early", 32'(a_done), 32'h0);
    step();
    chk("post_rst_done", 32'(a_done), 32'h1);
    chk("post_rst_sig", a_sig, 32'h0000_0002);

    // Full-size dump at base 0x80 with random data
    b_finish = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("b_daddr[%0d]", i), b_daddr, 32'h80 + 32'(i) * 4);
      step();
      chk($sformatf("b_data[%0d]", i), b_data, mem32[i]);
      chk($sformatf("b_index[%0d]", i), 32'(b_index), 32'(i));
      chk($sformatf("b_last[%0d]", i), 32'(b_last), (i == 31) ? 32'h1 : 32'h0);
      chk($sformatf("b_valid[%0d]", i), 32'(b_valid), 32'h1);
      step();
    end
    chk("b_dump_done", 32'(b_done), 32'h1);
    chk("b_busy", 32'(b_busy), 32'h0);
    chk("b_signature", b_sig, sig_model32());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
